// File: rtl/prim_dom_and_sched_pkg.sv
// Shared types for the DOM AND sequencing controller.
package prim_dom_and_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND  = 2'd1,
    MUL  = 2'd2,
    OUT  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/prim_dom_and_2share.sv
// Two-share domain-oriented-masking AND gadget; cross-domain terms are refreshed
// with the random word and registered, inner-domain terms stay combinational.
module prim_dom_and_2share
  import prim_dom_and_sched_pkg::*;
#(
  parameter int DW        = 64,
  parameter bit EnNegedge = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] b0_i,
  input  logic [DW-1:0] b1_i,
  input  logic          c_valid_i,
  input  logic [DW-1:0] c0_i,
  input  logic [DW-1:0] c1_i,
  output logic [DW-1:0] q0_o,
  output logic [DW-1:0] q1_o
);

  logic [DW-1:0] cross0_d, cross0_q;
  logic [DW-1:0] cross1_d, cross1_q;

  // The register is the glitch barrier between the domains: only refreshed terms cross it.
  always_comb begin
    cross0_d = cross0_q;
    cross1_d = cross1_q;
    if (c_valid_i) begin
      cross0_d = (a0_i & b1_i) ^ c0_i;
      cross1_d = (a1_i & b0_i) ^ c1_i;
    end
  end

  if (EnNegedge) begin : g_negedge
    always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cross0_q <= '0;
        cross1_q <= '0;
      end else begin
        cross0_q <= cross0_d;
        cross1_q <= cross1_d;
      end
    end
  end else begin : g_posedge
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cross0_q <= '0;
        cross1_q <= '0;
      end else begin
        cross0_q <= cross0_d;
        cross1_q <= cross1_d;
      end
    end
  end

  assign q0_o = (a0_i & b0_i) ^ cross0_q;
  assign q1_o = (a1_i & b1_i) ^ cross1_q;

endmodule

// File: rtl/prim_dom_and_sched.sv
// Sequencer around the DOM AND gadget: captures operands, fetches one fresh random
// word per operation, pulses the gadget once and presents the masked product.
module prim_dom_and_sched
  import prim_dom_and_sched_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] b0_i,
  input  logic [DW-1:0] b1_i,
  output logic          rnd_req_o,
  input  logic          rnd_ack_i,
  input  logic [DW-1:0] rnd_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] q0_o,
  output logic [DW-1:0] q1_o,
  output logic          busy_o
);

  sched_state_e  state_d, state_q;
  logic [DW-1:0] a0_d, a0_q, a1_d, a1_q, b0_d, b0_q, b1_d, b1_q;
  logic [DW-1:0] rnd_d, rnd_q;
  logic          c_valid;
  logic [DW-1:0] g_q0, g_q1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      rnd_q   <= rnd_d;
    end
  end

  // Clear wins over every handshake, including a late entropy ack.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid_i)  state_d = RND;
        RND:     if (rnd_ack_i)   state_d = MUL;
        MUL:                      state_d = OUT;
        OUT:     if (out_ready_i) state_d = IDLE;
        default:                  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    a0_d  = a0_q;
    a1_d  = a1_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    rnd_d = rnd_q;
    if (clr_i) begin
      a0_d  = '0;
      a1_d  = '0;
      b0_d  = '0;
      b1_d  = '0;
      rnd_d = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          a0_d = a0_i;
          a1_d = a1_i;
          b0_d = b0_i;
          b1_d = b1_i;
        end
        RND:  if (rnd_ack_i) rnd_d = rnd_data_i;
        MUL:  rnd_d = '0;
        OUT:  if (out_ready_i) begin
          a0_d = '0;
          a1_d = '0;
          b0_d = '0;
          b1_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    rnd_req_o   = (state_q == RND);
    c_valid     = (state_q == MUL);
    out_valid_o = (state_q == OUT);
    busy_o      = (state_q != IDLE);
  end

  // Both gadget random inputs take the same word; DOM recombination depends on it.
  prim_dom_and_2share #(
    .DW        (DW),
    .EnNegedge (1'b0)
  ) u_dom_and (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .a0_i      (a0_q),
    .a1_i      (a1_q),
    .b0_i      (b0_q),
    .b1_i      (b1_q),
    .c_valid_i (c_valid),
    .c0_i      (rnd_q),
    .c1_i      (rnd_q),
    .q0_o      (g_q0),
    .q1_o      (g_q1)
  );

  assign q0_o = out_valid_o ? g_q0 : '0;
  assign q1_o = out_valid_o ? g_q1 : '0;

endmodule

// File: doc/prim_dom_and_sched.md
# prim_dom_and_sched

Sequencing controller for the 2-share domain-oriented-masking AND gadget. It accepts one masked operand pair (a0,a1,b0,b1) over valid/ready, fetches one fresh DW-bit random word per operation, and holds the operands stable for the two cycles the gadget needs. It applies the same random word to both gadget random inputs, which a correct DOM recombination requires. It returns the masked product (q0,q1) over valid/ready. It sits between a masked datapath (S-box/Keccak chi stage) and the entropy distribution network.

## Interface
- DW, 64, share width in bits
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- clr_i  in  1  synchronous abort and wipe
- in_valid_i  in  1  operand request
- in_ready_o  out  1  controller can accept operands
- a0_i, a1_i, b0_i, b1_i  in  DW each  operand shares
- rnd_req_o  out  1  request one fresh random word
- rnd_ack_i  in  1  random word present on rnd_data_i this cycle
- rnd_data_i  in  DW  random word
- out_valid_o  out  1  result shares valid
- out_ready_i  in  1  consumer accepts result
- q0_o, q1_o  out  DW each  result shares
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, RND, MUL, OUT.
- **IDLE.** in_ready_o=1. On in_valid_i, register the four operand shares and go to RND.
- **RND.** rnd_req_o=1, held until rnd_ack_i. On rnd_ack_i, register rnd_data_i into the random register and go to MUL. rnd_data_i is ignored without ack.
- **MUL.** Exactly one cycle. Gadget c_valid_i=1. Gadget c0_i = c1_i = random register. Then go to OUT and zero the random register.
- **OUT.** out_valid_o=1. q0_o/q1_o are the gadget outputs, taken combinationally. They are stable because the operand registers are held and c_valid_i=0.
  - On out_ready_i: zero all operand registers and go to IDLE.
- Gadget c_valid_i=0 in every state except MUL. A random word is consumed by exactly one operation and is never reused.
- Outside OUT, q0_o/q1_o are forced to 0. Intermediate shares never appear on the output.
- **clr_i.** From any state, next state is IDLE, and operand and random registers are zeroed. The gadget's internal register is not cleared. It is overwritten on the next MUL.
  - clr_i has priority over every handshake in the same cycle.
  - An in-flight rnd_req_o drops. A late rnd_ack_i in IDLE is ignored.
- Unmasked result: q0_o^q1_o == (a0^a1)&(b0^b1).

## Timing
- **Reset values.** State IDLE; all registers 0. Outputs: in_ready_o=1, rnd_req_o=0, out_valid_o=0, q0_o=q1_o=0, busy_o=0.
- **Latency.** Handshake at edge N (IDLE). RND is active in cycle N+1. With ack in cycle N+1+k, MUL is in cycle N+2+k and out_valid_o rises in cycle N+3+k. The minimum is 3 cycles.
- **Throughput.** One operation in flight. in_ready_o=0 from RND through OUT. The earliest next accept is the cycle after the output handshake, so the minimum period is 4 cycles.
- in_ready_o, rnd_req_o, out_valid_o and busy_o are decoded from state only and are glitch-free w.r.t. inputs.
- **Reset assertion mid-operation.** Immediate return to reset values; the gadget's register also resets.
- **Output backpressure.** out_ready_i=0 holds OUT indefinitely, with q stable.

## Structure
- prim_dom_and_sched_pkg contains the state enum typedef (sched_state_e: IDLE, RND, MUL, OUT; 2-bit encoding).
- One sub-module: prim_dom_and_2share (u_dom_and), with DW=DW and EnNegedge=0. It shares clk_i/rst_ni.
- All else is local: operand registers (4×DW), random register (DW), state register.

## Test plan
- **Basic op.** a0=0xF0, a1=0x0F, b0=0xFF, b1=0x00 (DW=8), rnd=0xA5 acked the cycle after accept -> out_valid_o in cycle 3, q0^q1=0xFF, q0_o != 0xFF or q1_o != 0x00 (masked).
- **Delayed entropy.** Ack withheld 5 cycles -> rnd_req_o held 6 cycles, c_valid pulses once, out_valid_o 8 cycles after accept; a 50-random-op sweep with random masks always recombines correctly.
- **Backpressure.** out_ready_i=0 for 10 cycles in OUT -> q stable, in_ready_o=0; on release, the next accept is possible 1 cycle later and the operand registers read 0.
- **clr_i in RND and in OUT.** Clear -> IDLE next cycle, rnd_req_o=0, out_valid_o=0, q=0; a stray rnd_ack_i afterwards produces no state change.
- **Reset mid-MUL.** Deassert rst_ni -> all outputs at reset values; the following operation yields a correct result.
- **Entropy freshness.** A checker confirms each c_valid pulse uses a distinct acked word and c0_i==c1_i every MUL cycle.
